// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
// Frame entry layout: {stop_error, par_error, data[7:0]}.
package uart_pkg;
  localparam int UART_FW       = 10;
  localparam int UART_DATA_MSB = 7;
  localparam int UART_PAR_BIT  = 8;
  localparam int UART_STOP_BIT = 9;
  localparam int UART_DEPTH    = 8;
  localparam int UART_ECW      = 8;
endpackage

// File: rtl/uart_fifo_mem.sv
// Frame storage array.
// Synchronous write, combinational read, contents not reset.
module uart_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive frame FIFO with first-word-fall-through read side,
// sticky overflow and saturating frame-error counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = UART_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter bit DROP_ERR = 1'b0,
  parameter int ECW      = UART_ECW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           data_valid,
  input  logic [7:0]     p_data,
  input  logic           par_error,
  input  logic           stop_error,
  input  logic           rd_ready,
  output logic           rd_valid,
  output logic [7:0]     rd_data,
  output logic           rd_par_err,
  output logic           rd_stop_err,
  output logic [AW:0]    level,
  output logic           full,
  output logic           empty,
  output logic           overflow,
  output logic [ECW-1:0] err_cnt,
  input  logic           clr
);
  localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_rp;
  logic [AW:0]        r_level;
  logic               r_ovf;
  logic [ECW-1:0]     r_err_cnt;

  logic               w_err;
  logic               w_push_req;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic               w_lost;
  logic [UART_FW-1:0] w_wdata;
  logic [UART_FW-1:0] w_rdata;

  assign w_err      = par_error | stop_error;
  assign w_push_req = data_valid & ~(DROP_ERR & w_err);
  assign w_full     = (r_level == LVL_MAX);
  assign w_empty    = (r_level == '0);
  assign w_pop      = ~w_empty & rd_ready;
  // A full FIFO still takes a frame when the head leaves this cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_lost     = w_push_req & w_full & ~w_pop;
  assign w_wdata    = {stop_error, par_error, p_data};

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (UART_FW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wp),
    .i_wdata (w_wdata),
    .i_raddr (r_rp),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      // A new loss wins over a clear in the same cycle.
      if (w_lost)   r_ovf <= 1'b1;
      else if (clr) r_ovf <= 1'b0;
      if (clr)
        r_err_cnt <= '0;
      else if (data_valid & w_err & (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ECW'(1);
    end
  end

  assign rd_valid    = ~w_empty;
  assign rd_data     = w_rdata[UART_DATA_MSB:0];
  assign rd_par_err  = w_rdata[UART_PAR_BIT];
  assign rd_stop_err = w_rdata[UART_STOP_BIT];
  assign level       = r_level;
  assign full        = w_full;
  assign empty       = w_empty;
  assign overflow    = r_ovf;
  assign err_cnt     = r_err_cnt;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each completed frame (8-bit data plus parity/stop error flags) when the receiver pulses data_valid, and queues frames in a circular FIFO. Frames are presented to the host/bus side through a first-word-fall-through valid/ready interface. Also provides full/empty/level status, a sticky overflow flag and a saturating frame-error counter.

Parameters:
DEPTH, 8, number of frame entries; power of two, 2..256
AW, $clog2(DEPTH), pointer width; derived, not overridden
DROP_ERR, 0, 1 = frames with par_error or stop_error are counted but not stored
ECW, 8, width of the frame-error counter

Ports:
clk  in  1  clock, same clock as the receiver
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
data_valid  in  1  one-cycle strobe from receiver: frame complete
p_data  in  8  received byte, valid while data_valid=1
par_error  in  1  parity error for this frame, valid while data_valid=1
stop_error  in  1  stop-bit error for this frame, valid while data_valid=1
rd_ready  in  1  consumer accepts head entry
rd_valid  out  1  head entry available (= not empty)
rd_data  out  8  head byte
rd_par_err  out  1  head entry parity-error flag
rd_stop_err  out  1  head entry stop-error flag
level  out  AW+1  number of stored entries, 0..DEPTH
full  out  1  level==DEPTH
empty  out  1  level==0
overflow  out  1  sticky: a frame was lost because the FIFO was full
err_cnt  out  ECW  saturating count of frames with any error
clr  in  1  synchronous clear of overflow and err_cnt (does not flush data)

Behaviour:
- Storage: DEPTH x 10-bit entries {stop_error, par_error, p_data}; write pointer wp, read pointer rp, AW bits each, wrap DEPTH-1 -> 0; count register level.
- Reset (rst=0 at posedge): wp=0, rp=0, level=0, overflow=0, err_cnt=0. Consequently rd_valid=0, empty=1, full=0. Storage contents not reset; rd_data/rd_* flags are don't-care while empty. Reset mid-frame or mid-read discards all entries.
- push_req = data_valid & ~(DROP_ERR & (par_error|stop_error)).
- pop = rd_valid & rd_ready (pop while empty is ignored, with no state change).
- push accepted = push_req & (~full | pop). Push into a full FIFO is accepted when a pop occurs in the same cycle; level is unchanged.
- Accepted push: entry written at wp, wp+1 on the same edge. Pop: rp+1.
- level next = level + push - pop. Simultaneous push and pop on an empty FIFO cannot occur because rd_valid=0; the push alone is taken.
- Latency: an entry written at edge N drives rd_valid=1 and rd_data starting in cycle N+1 (FWFT). Read outputs are combinational from storage[rp].
- Overflow: push_req & full & ~pop -> frame dropped, overflow<=1. Held until clr=1 or reset. If clr and a new overflow occur in the same cycle, overflow ends as 1.
- Error counter: err_cnt increments on data_valid & (par_error|stop_error), whether the frame is stored, dropped by DROP_ERR or lost to overflow. Saturates at 2^ECW-1. clr has priority over increment in the same cycle (result 0).
- data_valid is a single-cycle strobe per frame. Two consecutive high cycles are two frames.
- full/empty are derived from level. level never exceeds DEPTH, and no pointer aliasing is permitted.

Decomposition:
- Shared package uart_pkg: frame-entry width constant (10), field positions (DATA 7:0, PAR 8, STOP 9), default DEPTH/ECW.
- One natural sub-module: uart_fifo_mem, a DEPTH x W register array with synchronous write and combinational read. The pointer/level/flag control lives in uart_rx_fifo.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with data_valid=1 -> after release, level=0, empty=1, rd_valid=0, err_cnt=0, overflow=0.
- Ordering/latency: push 0xA5, 0x3C, 0xFF on consecutive cycles, rd_ready=0 -> rd_valid rises the cycle after the first push, rd_data=0xA5, level=3. Then rd_ready=1 -> outputs 0xA5, 0x3C, 0xFF in order, empty=1.
- Full/overflow (DEPTH=4): push 5 frames with no reads -> full=1 after the 4th, the 5th is dropped, overflow=1, level=4. Read back 4 frames; the 5th byte is absent. clr=1 -> overflow=0.
- Push+pop at full: FIFO full, data_valid=1 (0x55) with rd_ready=1 -> level stays 4, overflow stays 0, 0x55 is read last. Wrap across index 3->0 is verified.
- Error flags: frames with par_error=1 (0x11) and stop_error=1 (0x22), DROP_ERR=0 -> stored with rd_par_err/rd_stop_err set, err_cnt=2. With DROP_ERR=1 -> neither is stored, err_cnt=2, level=0.
- Saturation/clear: ECW=2, 5 errored frames -> err_cnt=3. clr together with an errored frame -> err_cnt=0. Reset asserted mid-readout -> FIFO empty the next cycle.
